// File: rtl/celloutsig_pkg.sv
`timescale 1ns/1ps
// Shared constants and result type for the pipelined celloutsig evaluator.
package celloutsig_pkg;

   localparam int unsigned WORD_W   = 96;
   localparam int unsigned HIT_B    = 0;
   localparam int unsigned C2_LO    = 1;
   localparam int unsigned STICKY_B = 7;
   localparam int unsigned CNT_LO   = 8;

   typedef struct packed {
      logic [5:0] c2;
      logic       hit;
   } cell_res_t;

endpackage

// File: rtl/celloutsig_cell.sv
`timescale 1ns/1ps
// Combinational 96-bit cell function; one instance per lane.
module celloutsig_cell
   import celloutsig_pkg::*;
(
   input  logic [WORD_W-1:0] w,
   output cell_res_t         res
);

   logic [3:0] c1;
   logic       c5;
   logic       c6;
   logic       c7;
   logic       unused_bits;

   assign c1      = w[18:15] ^ {w[42:40], 1'b1};
   assign c5      = ~(c1[3] & w[67]);
   assign c6      = ~(w[86] & c5);
   assign c7      = ~c6;
   assign res.c2  = ~{w[43:42], c1};
   assign res.hit = w[3] & ~c7;

   // Most of the word does not influence the cell.
   assign unused_bits = ^w;

endmodule

// File: rtl/celloutsig_pipe.sv
`timescale 1ns/1ps
// celloutsig_pipe: multi-lane pipelined cell evaluator with valid/ready flow control,
// per-lane sticky flags and optional saturating hit counters (CELLOUTSIG_CNT_EN).
module celloutsig_pipe
   import celloutsig_pkg::*;
#(
   parameter int unsigned LANES = 2,
   parameter int unsigned DEPTH = 3,
   parameter int unsigned CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*WORD_W-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*WORD_W-1:0] out_data,
   input  logic                    clear
);

   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] rdy;
   cell_res_t        res [LANES];
   cell_res_t        d   [DEPTH][LANES];
   logic             hs;

   for (genvar k = 0; k < LANES; k++) begin : g_cell
      celloutsig_cell u_cell (
         .w   (in_data[k*WORD_W +: WORD_W]),
         .res (res[k])
      );
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic      vin;
      cell_res_t din [LANES];

      if (i == 0) begin : g_src
         assign vin = in_valid;
         assign din = res;
      end else begin : g_src
         assign vin = v[i-1];
         assign din = d[i-1];
      end

      // A stage may load unless it and every stage after it is full while the sink stalls.
      assign rdy[i] = out_ready | ~(&v[DEPTH-1:i]);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v[i] <= 1'b0;
            d[i] <= '{default: '0};
         end else if (rdy[i]) begin
            v[i] <= vin;
            d[i] <= din;
         end
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = v[DEPTH-1];
   assign hs        = out_valid & out_ready;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      cell_res_t         r;
      logic              sticky;
      logic [CNT_W-1:0]  cnt;
      logic [WORD_W-1:0] word;

      assign r = d[DEPTH-1][k];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sticky <= 1'b0;
         end else if (clear) begin
            sticky <= 1'b0;
         end else if (hs) begin
            sticky <= sticky | r.hit;
         end
      end

`ifdef CELLOUTSIG_CNT_EN
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt <= '0;
         end else if (clear) begin
            cnt <= '0;
         end else if (hs && r.hit && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
`else
      assign cnt = '0;
`endif

      // Sticky and count show state from before the current beat's update.
      always_comb begin
         word                 = '0;
         word[HIT_B]          = r.hit;
         word[C2_LO +: 6]     = r.c2;
         word[STICKY_B]       = sticky;
         word[CNT_LO +: CNT_W] = cnt;
      end

      assign out_data[k*WORD_W +: WORD_W] = word;
   end

endmodule

// File: doc/celloutsig_pipe.md
# celloutsig_pipe

Multi-lane, pipelined successor of the single-cell combinational celloutsig evaluator. Each lane applies the fixed 96-bit cell function to its input word, carries the result through a parametrised register pipeline with valid/ready flow control, and keeps a sticky flag and an optional saturating hit counter, all reported in the lane's output word. The block sits between the stimulus source and the checker, where the old purely combinational cell had no flow control or state.

## Interface
- LANES, 2: number of independent 96-bit lanes (1..8).
- DEPTH, 3: pipeline register stages (1..4).
- CNT_W, 16: per-lane hit counter width (1..32).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  LANES*96  lane k occupies bits [96k+95:96k].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*96  per-lane result word.
- clear  in  1  synchronous clear of all sticky flags and counters.

## Operation
- Cell function per lane, with word w = lane slice:
  - c1[3:0] = w[18:15] ^ {w[42:40], 1'b1}
  - c2[5:0] = ~{w[43:42], c1}
  - c5 = ~(c1[3] & w[67]), c6 = ~(w[86] & c5), c7 = ~c6
  - hit = w[3] & ~c7
- Evaluated combinationally on in_data and captured into stage 0 on accept (in_valid && in_ready). The 7-bit result {c2, hit} then advances through DEPTH stages.
- Output word per lane:
  - bit 0 = hit
  - bits 6:1 = c2
  - bit 7 = sticky
  - bits 8+CNT_W-1:8 = count
  - all other bits 0
- Sticky and count fields show the lane's registered values before the current output beat's update.
- On output handshake (out_valid && out_ready): sticky |= hit, and count += hit, saturating at 2^CNT_W−1.
- clear: sticky and count go to 0 on the next edge. clear wins over a simultaneous handshake update. The pipeline contents are not affected.

## Timing
- Reset: all stage valids, stickies and counts = 0; out_valid = 0; out_data = 0; in_ready = 1 once reset deasserts.
- Latency: with out_ready held high, a beat accepted at edge n gives out_valid in cycle n+DEPTH−1 after that edge, i.e. DEPTH register stages.
- Throughput: one beat per cycle when out_ready is high.
- Stage i advances when stage i+1 is empty or advancing. The last stage advances on out_ready. in_ready = !v[0] || stage 0 advances. The ready path is combinational back through the stages.
- Stall: out_valid and out_data stay stable while out_ready is low. No beat is dropped or duplicated. A full pipeline holds DEPTH beats.
- Reset asserted mid-stream: in-flight beats are discarded immediately.

## Configuration
- CELLOUTSIG_CNT_EN defined: counters are instantiated and behave as described.
- CELLOUTSIG_CNT_EN undefined: no counter flops; the count field reads 0. Sticky, pipeline and handshake behaviour are unchanged. CNT_W is ignored.

## Structure
- Package celloutsig_pkg holds:
  - WORD_W = 96
  - bit-index constants (HIT_B=0, C2_LO=1, STICKY_B=7, CNT_LO=8)
  - typedef cell_res_t, a packed struct {logic [5:0] c2; logic hit;}
- One sub-module, celloutsig_cell: the combinational 96-bit to cell_res_t function, instantiated once per lane.
- The top level holds the pipeline and the per-lane sticky and counter state.

## Test plan
- Reset, then lane0 in_data=96'h8 with out_ready=1 → after DEPTH cycles lane0 out_data[7:0]=8'h7D (hit=1, c2=6'h3E, sticky=0). Next beat shows sticky=1 and count=1.
- Lane0 in_data=(1<<86)|8 → hit=0, out_data[7:0]=8'h7C. Lane0 in_data bits {86,67,18,3} set → hit=1.
- Hold out_ready=0 while feeding 5 beats (DEPTH=3) → in_ready drops after 3 accepts and out_data stays stable. Release → exactly 5 beats out, in order.
- CNT_W=2, send 5 hit beats → count field reads 0,1,2,3,3.
- Assert clear in the same cycle as a hit handshake → next beat shows sticky=0, count=0.
- Assert rst while 2 beats are in flight → out_valid=0 immediately; no stale beats appear after reset.
